leaf_out_port_arbiter: RTL and testbench
========================================

// Module: leaf_out_port_arbiter
// PURPOSE
//  Round-robin read scheduler for the per-leaf output port cluster. Watches the per-port FIFO empty flags,
//  pulses rd_en_sel for one granted port, captures that port's internal_out packet, and presents it on a
//  single valid/ready stream toward the leaf interface/NoC switch. Enforces a per-grant burst limit and
//  quiesces cleanly in done mode.
// PARAMETERS
//  PACKET_BITS     97  width of one NoC packet
//  NUM_OUT_PORTS   7   number of output ports arbitrated
//  PORT_SEL_BITS   3   clog2(NUM_OUT_PORTS); grant index width
//  MAX_BURST       4   max consecutive packets from one port before rotation (>=1)
//  CNT_BITS        32  width of forwarded-packet counter
// PORTS
//  clk              in   1                          clock; single clock domain
//  reset            in   1                          synchronous, active-high reset
//  empty            in   NUM_OUT_PORTS              per-port FIFO empty flags
//  internal_out     in   PACKET_BITS*NUM_OUT_PORTS  per-port FIFO data; port i at [PACKET_BITS*(i+1)-1:PACKET_BITS*i]
//  rd_en_sel        out  NUM_OUT_PORTS              one-hot, one-cycle FIFO pop strobe
//  pkt_out          out  PACKET_BITS                captured packet
//  pkt_vld          out  1                          pkt_out valid
//  pkt_rdy          in   1                          downstream accepts when pkt_vld&&pkt_rdy
//  grant_idx        out  PORT_SEL_BITS              port that sourced pkt_out
//  is_done_mode     in   1                          level; stop issuing new pops
//  arb_idle         out  1                          high when in IDLE with no packet held
//  pkt_fwd_cnt      out  CNT_BITS                   total packets handed downstream
// BEHAVIOUR
//  Reset values: rd_en_sel=0, pkt_out=0, pkt_vld=0, grant_idx=0, last_grant=NUM_OUT_PORTS-1, burst_cnt=0,
//   pkt_fwd_cnt=0, state=IDLE, arb_idle=1. Reset mid-operation drops any popped/held packet (FIFOs reset too).
//  FIFO read latency fixed at 1: data on internal_out[g] is valid the cycle after rd_en_sel[g].
//  FSM states:
//   IDLE: if !is_done_mode && |~empty: grant = first non-empty port scanning last_grant+1 .. wrapping mod
//         NUM_OUT_PORTS; latch grant_idx, burst_cnt<=1 -> READ. Else stay.
//   READ: rd_en_sel[grant_idx]=1 for exactly this cycle -> CAPTURE.
//   CAPTURE: pkt_out<=internal_out[grant_idx]; pkt_vld<=1 -> SEND.
//   SEND: hold pkt_out/pkt_vld stable until pkt_rdy. On handshake: pkt_vld<=0, pkt_fwd_cnt+=1 (wraps at
//         2^CNT_BITS), last_grant<=grant_idx; then
//         - if !is_done_mode && !empty[grant_idx] && burst_cnt<MAX_BURST: burst_cnt+=1 -> READ (same port);
//         - else burst_cnt<=0 -> IDLE.
//  Throughput: 3 cycles/packet best case (READ,CAPTURE,SEND with pkt_rdy=1); no overlap of pops.
//  rd_en_sel is never asserted for a port whose empty is high in the decision cycle; at most one bit set.
//  is_done_mode: sampled only in IDLE and at SEND handshake; an in-flight packet always completes.
//  arb_idle = (state==IDLE); used by done-mode logic to know the cluster is drained of held packets.
//  Empty flag rising on the granted port between IDLE and READ cannot occur (arbiter is the sole reader).
//  grant_idx values >= NUM_OUT_PORTS never produced; empty/internal_out bits above NUM_OUT_PORTS ignored.
//  No combinational path pkt_rdy -> pkt_vld or empty -> rd_en_sel; rd_en_sel decoded from state+grant_idx regs.
// STRUCTURE
//  Shared package: arb state enum (IDLE, READ, CAPTURE, SEND), PACKET_BITS and port-count constants shared
//   with the output port cluster.
//  One sub-module: rr_pick_next (combinational rotate-priority encoder: req vector + last_grant -> next
//   grant index + any_req). FSM, data capture register and counter stay in the top.
// TESTING
//  1. Reset, empty=7'h7F: hold 20 cycles -> rd_en_sel=0, pkt_vld=0, arb_idle=1, pkt_fwd_cnt=0.
//  2. Only port 3 non-empty with 1 packet, pkt_rdy=1 -> rd_en_sel=7'h08 one cycle, pkt_vld 2 cycles later
//     with port-3 data, grant_idx=3, pkt_fwd_cnt=1, back to IDLE.
//  3. All ports hold 10 packets, MAX_BURST=4, pkt_rdy=1 -> grant order 0x4,1x4,2x4,...,6x4,0x4...; each pop
//     3 cycles apart; no two rd_en_sel bits ever high.
//  4. Port 5 granted, pkt_rdy=0 for 15 cycles -> pkt_out/grant_idx stable, no further pops; release ->
//     single handshake, counter +1.
//  5. is_done_mode asserted while in CAPTURE with other ports non-empty -> packet completes, FSM returns to
//     IDLE, no further rd_en_sel, arb_idle=1.
//  6. reset asserted in SEND -> next cycle all outputs at reset values; after release, arbitration restarts
//     at port 0.

Source files
------------

// File: rtl/leaf_out_port_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the leaf output port
// cluster and its round-robin read arbiter.
package leaf_out_port_arbiter_pkg;

  localparam int PACKET_BITS   = 97;
  localparam int NUM_OUT_PORTS = 7;
  localparam int PORT_SEL_BITS = 3;
  localparam int MAX_BURST     = 4;
  localparam int CNT_BITS      = 32;
  // Needs to hold the value MAX_BURST itself, not just MAX_BURST-1.
  localparam int BURST_BITS    = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_SEND
  } arb_state_t;

  typedef logic [PACKET_BITS-1:0]                      pkt_t;
  typedef logic [NUM_OUT_PORTS-1:0]                    port_vec_t;
  typedef logic [PORT_SEL_BITS-1:0]                    port_sel_t;
  // Packed so that port i sits at [PACKET_BITS*(i+1)-1 : PACKET_BITS*i].
  typedef logic [NUM_OUT_PORTS-1:0][PACKET_BITS-1:0]   pkt_arr_t;

  // One-hot decode of a port index; out-of-range indices decode to zero.
  function automatic port_vec_t port_onehot(input port_sel_t sel);
    port_vec_t v;
    v = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      if (port_sel_t'(i) == sel) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/leaf_out_port_arbiter_if.sv
// FIFO-side and stream-side signals of the output port arbiter.
// master = arbiter, slave = FIFO cluster / downstream switch.
interface leaf_out_port_arbiter_if;
  import leaf_out_port_arbiter_pkg::*;

  port_vec_t empty;         // per-port FIFO empty flags
  pkt_arr_t  internal_out;  // per-port FIFO head data (1-cycle read latency)
  port_vec_t rd_en_sel;     // one-hot pop strobe
  pkt_t      pkt_out;       // captured packet
  logic      pkt_vld;
  logic      pkt_rdy;
  port_sel_t grant_idx;     // port that sourced pkt_out

  modport master (
    input  empty, internal_out, pkt_rdy,
    output rd_en_sel, pkt_out, pkt_vld, grant_idx
  );

  modport slave (
    output empty, internal_out, pkt_rdy,
    input  rd_en_sel, pkt_out, pkt_vld, grant_idx
  );

endinterface

// File: rtl/leaf_out_port_arbiter_rr_pick_next.sv
// Rotate-priority encoder: first requesting port strictly after `last`,
// wrapping modulo N. `last` itself has the lowest priority.
module rr_pick_next
  import leaf_out_port_arbiter_pkg::*;
#(
  parameter int N = NUM_OUT_PORTS,
  parameter int W = PORT_SEL_BITS
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] next,
  output logic         any
);

  // Scan offsets 1..N from last; the first hit wins.
  always_comb begin : scan
    int idx;
    idx  = 0;
    any  = 1'b0;
    next = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!any && req[idx]) begin
        any  = 1'b1;
        next = W'(idx);
      end
    end
  end

endmodule

// File: rtl/leaf_out_port_arbiter.sv
// Round-robin read scheduler for the per-leaf output port cluster.
// Pops one granted FIFO at a time, captures its packet and presents it on a
// valid/ready stream; bursts up to MAX_BURST packets per grant.
module leaf_out_port_arbiter
  import leaf_out_port_arbiter_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  leaf_out_port_arbiter_if.master      bus,
  input  logic                         is_done_mode,
  output logic                         arb_idle,
  output logic [CNT_BITS-1:0]          pkt_fwd_cnt
);

  arb_state_t            state;
  port_sel_t             grant_idx;
  port_sel_t             last_grant;
  logic [BURST_BITS-1:0] burst_cnt;
  pkt_t                  pkt_out;
  logic                  pkt_vld;

  port_sel_t             pick_idx;
  logic                  pick_any;

  rr_pick_next #(
    .N (NUM_OUT_PORTS),
    .W (PORT_SEL_BITS)
  ) u_pick (
    .req  (~bus.empty),
    .last (last_grant),
    .next (pick_idx),
    .any  (pick_any)
  );

  // Pop strobe and idle flag are decoded from registers only, so neither
  // empty nor pkt_rdy has a combinational path to the outputs.
  assign bus.rd_en_sel = (state == ST_READ) ? port_onehot(grant_idx) : '0;
  assign arb_idle      = (state == ST_IDLE);
  assign bus.pkt_out   = pkt_out;
  assign bus.pkt_vld   = pkt_vld;
  assign bus.grant_idx = grant_idx;

  // Arbitration FSM with capture register, burst limit and forward counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant_idx   <= '0;
      last_grant  <= port_sel_t'(NUM_OUT_PORTS - 1);
      burst_cnt   <= '0;
      pkt_out     <= '0;
      pkt_vld     <= 1'b0;
      pkt_fwd_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!is_done_mode && pick_any) begin
            grant_idx <= pick_idx;
            burst_cnt <= BURST_BITS'(1);
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // FIFO data is valid the cycle after the pop.
          pkt_out <= bus.internal_out[grant_idx];
          pkt_vld <= 1'b1;
          state   <= ST_SEND;
        end
        ST_SEND: begin
          if (bus.pkt_rdy) begin
            pkt_vld     <= 1'b0;
            pkt_fwd_cnt <= pkt_fwd_cnt + CNT_BITS'(1);
            last_grant  <= grant_idx;
            if (!is_done_mode && !bus.empty[grant_idx] &&
                burst_cnt < BURST_BITS'(MAX_BURST)) begin
              burst_cnt <= burst_cnt + BURST_BITS'(1);
              state     <= ST_READ;
            end else begin
              burst_cnt <= '0;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_out_port_arbiter.sv
// Directed bench for leaf_out_port_arbiter with a behavioural FIFO cluster.
module tb_leaf_out_port_arbiter;
  import leaf_out_port_arbiter_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                is_done_mode;
  logic                arb_idle;
  logic [CNT_BITS-1:0] pkt_fwd_cnt;

  leaf_out_port_arbiter_if bus();

  leaf_out_port_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.master),
    .is_done_mode (is_done_mode),
    .arb_idle     (arb_idle),
    .pkt_fwd_cnt  (pkt_fwd_cnt)
  );

  always #5 clk = ~clk;

  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   viol = 0;
  int   fill   [NUM_OUT_PORTS];
  int   popped [NUM_OUT_PORTS];
  pkt_t data_q [NUM_OUT_PORTS];
  int   pop_port [$];
  int   pop_cyc  [$];
  pkt_t hs_pkt   [$];

  function automatic pkt_t mkpkt(input int port, input int seq);
    return {1'b1, 32'hA5A50000 | 32'(seq), 32'(seq * 3 + port), 32'h1000 + 32'(port)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO cluster model: empty from fill/pop counts, data registered on pop.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      bus.empty[i]        = (popped[i] >= fill[i]);
      bus.internal_out[i] = data_q[i];
    end
  end

  initial begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      popped[i] = 0;
      data_q[i] = '0;
    end
  end

  // Pop handling, pop/handshake logging and protocol violation tracking.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ($countones(bus.rd_en_sel) > 1) viol <= viol + 1;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (bus.rd_en_sel[i]) begin
        if (bus.empty[i]) viol <= viol + 1;
        data_q[i] <= mkpkt(i, popped[i]);
        popped[i] <= popped[i] + 1;
        pop_port.push_back(i);
        pop_cyc.push_back(cyc);
      end
    end
    if (bus.pkt_vld && bus.pkt_rdy && !reset) hs_pkt.push_back(bus.pkt_out);
  end

  // kind 0: pop strobe, 1: pkt_vld, 2: idle and fully drained
  task automatic wait_cond(input int kind, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      case (kind)
        0:       ok = (bus.rd_en_sel != '0);
        1:       ok = bus.pkt_vld;
        default: ok = arb_idle && (&bus.empty) && !bus.pkt_vld;
      endcase
    end
    chk(tag, ok, 1'b1);
  endtask

  initial begin
    int   n0, c0, g0;
    int   base [NUM_OUT_PORTS];
    int   exp_port [$];
    int   nth  [NUM_OUT_PORTS];
    pkt_t p0;

    for (int i = 0; i < NUM_OUT_PORTS; i++) fill[i] = 0;
    reset        = 1'b1;
    is_done_mode = 1'b0;
    bus.pkt_rdy  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: all empty for 20 cycles
    repeat (20) @(negedge clk);
    chk("t1_rd_en", bus.rd_en_sel, 0);
    chk("t1_vld", bus.pkt_vld, 0);
    chk("t1_idle", arb_idle, 1);
    chk("t1_cnt", pkt_fwd_cnt, 0);
    chk("t1_grant", bus.grant_idx, 0);
    chk("t1_pkt", bus.pkt_out, 0);
    chk("t1_pops", pop_port.size(), 0);

    // 2: single packet on port 3
    bus.pkt_rdy = 1'b1;
    fill[3] = 1;
    wait_cond(0, "t2_wait_pop");
    chk("t2_rd_en", bus.rd_en_sel, 7'h08);
    @(negedge clk);
    chk("t2_rd_en_once", bus.rd_en_sel, 0);
    chk("t2_vld_capture", bus.pkt_vld, 0);
    @(negedge clk);
    chk("t2_vld", bus.pkt_vld, 1);
    chk("t2_pkt", bus.pkt_out, mkpkt(3, 0));
    chk("t2_grant", bus.grant_idx, 3);
    @(negedge clk);
    chk("t2_vld_drop", bus.pkt_vld, 0);
    chk("t2_cnt", pkt_fwd_cnt, 1);
    chk("t2_idle", arb_idle, 1);

    // 3: all ports 10 packets after reset -> bursts of 4 starting at port 0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t3_cnt_rst", pkt_fwd_cnt, 0);
    n0 = pop_port.size();
    c0 = hs_pkt.size();
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      base[i] = popped[i];
      nth[i]  = 0;
      fill[i] = popped[i] + 10;
    end
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < NUM_OUT_PORTS; p++)
        repeat (r < 2 ? 4 : 2) exp_port.push_back(p);
    wait_cond(2, "t3_drain");
    chk("t3_npops", pop_port.size() - n0, 70);
    chk("t3_cnt", pkt_fwd_cnt, 70);
    if (pop_port.size() - n0 == 70 && hs_pkt.size() - c0 == 70) begin
      for (int k = 0; k < 70; k++) begin
        chk($sformatf("t3_order_%0d", k), pop_port[n0 + k], exp_port[k]);
        chk($sformatf("t3_data_%0d", k), hs_pkt[c0 + k],
            mkpkt(exp_port[k], base[exp_port[k]] + nth[exp_port[k]]));
        nth[exp_port[k]]++;
        if (k > 0 && exp_port[k] == exp_port[k-1])
          chk($sformatf("t3_gap_%0d", k), pop_cyc[n0 + k] - pop_cyc[n0 + k - 1], 3);
      end
    end

    // 4: port 5 stalled by pkt_rdy=0 for 15 cycles
    bus.pkt_rdy = 1'b0;
    fill[5] = popped[5] + 3;
    base[5] = popped[5];
    wait_cond(1, "t4_wait_vld");
    chk("t4_grant", bus.grant_idx, 5);
    chk("t4_pkt", bus.pkt_out, mkpkt(5, base[5]));
    p0 = bus.pkt_out;
    g0 = int'(bus.grant_idx);
    n0 = pop_port.size();
    c0 = int'(pkt_fwd_cnt);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("t4_hold_vld", bus.pkt_vld, 1);
      chk("t4_hold_pkt", bus.pkt_out, p0);
      chk("t4_hold_grant", bus.grant_idx, g0);
    end
    chk("t4_no_pop", pop_port.size(), n0);
    bus.pkt_rdy = 1'b1;
    @(negedge clk);
    bus.pkt_rdy = 1'b0;
    chk("t4_cnt", pkt_fwd_cnt, c0 + 1);
    chk("t4_vld_drop", bus.pkt_vld, 0);
    bus.pkt_rdy = 1'b1;
    wait_cond(2, "t4_drain");
    chk("t4_total", pkt_fwd_cnt, c0 + 3);

    // 5: done mode raised during CAPTURE; last grant was 5 so port 6 is next
    for (int i = 0; i < NUM_OUT_PORTS; i++) fill[i] = popped[i] + 2;
    n0 = pop_port.size();
    c0 = int'(pkt_fwd_cnt);
    wait_cond(0, "t5_wait_pop");
    chk("t5_rd_en", bus.rd_en_sel, 7'h40);
    @(negedge clk);
    is_done_mode = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_one_pop", pop_port.size(), n0 + 1);
    chk("t5_cnt", pkt_fwd_cnt, c0 + 1);
    chk("t5_idle", arb_idle, 1);
    chk("t5_vld", bus.pkt_vld, 0);
    chk("t5_rd_en_off", bus.rd_en_sel, 0);
    is_done_mode = 1'b0;
    wait_cond(2, "t5_drain");

    // 6: reset while holding a packet in SEND
    bus.pkt_rdy = 1'b0;
    fill[2] = popped[2] + 5;
    wait_cond(1, "t6_wait_vld");
    chk("t6_grant", bus.grant_idx, 2);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_rd_en", bus.rd_en_sel, 0);
    chk("t6_rst_vld", bus.pkt_vld, 0);
    chk("t6_rst_pkt", bus.pkt_out, 0);
    chk("t6_rst_grant", bus.grant_idx, 0);
    chk("t6_rst_idle", arb_idle, 1);
    chk("t6_rst_cnt", pkt_fwd_cnt, 0);
    for (int i = 0; i < NUM_OUT_PORTS; i++) fill[i] = popped[i];
    reset = 1'b0;
    fill[0] = popped[0] + 1;
    fill[4] = popped[4] + 1;
    bus.pkt_rdy = 1'b1;
    n0 = pop_port.size();
    wait_cond(0, "t6_wait_pop");
    chk("t6_first", bus.rd_en_sel, 7'h01);
    wait_cond(2, "t6_drain");
    chk("t6_npops", pop_port.size() - n0, 2);
    if (pop_port.size() - n0 == 2) chk("t6_second", pop_port[n0 + 1], 4);
    chk("t6_cnt", pkt_fwd_cnt, 2);

    chk("no_bad_pop", viol, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
